// File: rtl/pac_sprite_anim_pkg.sv
// pac_sprite_pkg: direction/phase/state constants and the sprite bitmaps (death frames only with PAC_DEATH_ANIM_EN).
package pac_sprite_pkg;
  localparam int BMP_W = 12;
  localparam int BMP_H = 12;
  localparam int BMP_N = BMP_W * BMP_H;
  localparam int IDX_W = $clog2(BMP_N);
  typedef logic [BMP_N-1:0] bmp_t;
  typedef logic [IDX_W-1:0] idx_t;
  localparam logic [3:0] DIR_NONE = 4'b0000;
  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;
  typedef enum logic [1:0] {PH_OPEN, PH_HALF, PH_CLOSED} phase_t;
  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_DYING = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
`ifdef PAC_DEATH_ANIM_EN
  localparam int NFRAMES = 17;
`else
  localparam int NFRAMES = 9;
`endif
  localparam int FSEL_W = $clog2(NFRAMES);
  typedef logic [FSEL_W-1:0] fsel_t;
  localparam bmp_t ROUND = {
    12'b000011110000, 12'b001111111100, 12'b011111111110, 12'b011111111110,
    12'b111111111111, 12'b111111111111, 12'b111111111111, 12'b111111111111,
    12'b011111111110, 12'b011111111110, 12'b001111111100, 12'b000011110000};
  localparam bmp_t R_OPEN = {
    12'b000011110000, 12'b001111111100, 12'b011111111100, 12'b011111110000,
    12'b111111000000, 12'b111110000000, 12'b111110000000, 12'b111111000000,
    12'b011111110000, 12'b011111111100, 12'b001111111100, 12'b000011110000};
  localparam bmp_t R_HALF = {
    12'b000011110000, 12'b001111111100, 12'b011111111110, 12'b011111111110,
    12'b111111111100, 12'b111111100000, 12'b111111100000, 12'b111111111100,
    12'b011111111110, 12'b011111111110, 12'b001111111100, 12'b000011110000};
  function automatic idx_t bi(int r, int c);
    return idx_t'((BMP_H - 1 - r) * BMP_W + BMP_W - 1 - c);
  endfunction
  // k: 0 keep (right), 1 mirror (left), 2 rotate mouth up, 3 rotate mouth down
  function automatic bmp_t orient(bmp_t b, int k);
    bmp_t o = '0;
    for (int r = 0; r < BMP_H; r++)
      for (int c = 0; c < BMP_W; c++)
        o[bi(r, c)] = k == 0 ? b[bi(r, c)] : k == 1 ? b[bi(r, BMP_W - 1 - c)] :
                      k == 2 ? b[bi(c, BMP_W - 1 - r)] : b[bi(c, r)];
    return o;
  endfunction
  function automatic bmp_t death(int f);
    bmp_t o = '0;
    for (int r = 0; r < BMP_H; r++)
      for (int c = 0; c < BMP_W; c++) begin
        int dx = 2 * c - (BMP_W - 1);
        int dy = (BMP_H - 1) - 2 * r;
        o[bi(r, c)] = f < 7 && ROUND[bi(r, c)] && !(dy > 0 && 2 * (dx < 0 ? -dx : dx) < dy * (f + 1));
      end
    return o;
  endfunction
  // 0 round, 1..8 {dir L,U,R,D} x {OPEN,HALF}, 9..16 death frames
  function automatic bmp_t frame_bmp(int i);
    int k = (i - 1) / 2;
`ifdef PAC_DEATH_ANIM_EN
    if (i >= 9) return death(i - 9);
`endif
    if (i == 0) return ROUND;
    return orient((i - 1) % 2 == 1 ? R_HALF : R_OPEN, k == 0 ? 1 : k == 1 ? 2 : k == 2 ? 0 : 3);
  endfunction
endpackage

// File: rtl/pac_sprite_anim_if.sv
// pac_sprite_anim_if: per-pixel query/response bundle between scan logic and the sprite generator.
interface pac_sprite_anim_if #(parameter int COORD_W = 5);
  logic pix_req;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic pix_valid;
  logic pixel;
  modport master (output pix_req, x, y, input pix_valid, pixel);
  modport slave (input pix_req, x, y, output pix_valid, pixel);
endinterface

// File: rtl/pac_sprite_anim_rom.sv
// pac_sprite_rom: combinational (frame_sel, r, c) -> bitmap bit, zero outside the sprite box.
module pac_sprite_rom
  import pac_sprite_pkg::*;
#(
  parameter int SPRITE_W = BMP_W,
  parameter int SPRITE_H = BMP_H,
  parameter int COORD_W = 5
) (
  input  fsel_t              frame_sel,
  input  logic [COORD_W-1:0] r,
  input  logic [COORD_W-1:0] c,
  output logic               on
);
  bmp_t rom [NFRAMES];
  idx_t idx;
  for (genvar i = 0; i < NFRAMES; i++) begin : g_rom
    assign rom[i] = frame_bmp(i);
  end
  always_comb begin
    idx = idx_t'((SPRITE_H - 1 - int'(r)) * SPRITE_W + SPRITE_W - 1 - int'(c));
    on = int'(r) < SPRITE_H && int'(c) < SPRITE_W && rom[frame_sel][idx];
  end
endmodule

// File: rtl/pac_sprite_anim.sv
// pac_sprite_anim: animated Pac-Man pixel generator with 1-cycle registered lookup.
// Death sequence is built only when PAC_DEATH_ANIM_EN is defined.
module pac_sprite_anim
  import pac_sprite_pkg::*;
#(
  parameter int SPRITE_W = BMP_W,
  parameter int SPRITE_H = BMP_H,
  parameter int SCALE_LOG2 = 1,
  parameter int COORD_W = 5,
  parameter int ANIM_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [3:0]           direction,
  input  logic                 moving,
  input  logic                 die,
  input  logic                 revive,
  pac_sprite_anim_if.slave     q,
  output logic                 dead_done
);
  localparam int CW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  logic [3:0] dir_q;
  logic [1:0] step;
  logic [1:0] state;
  logic [2:0] dframe;
  logic [CW-1:0] anim_cnt;
  logic wrap;
  logic on;
  phase_t phase;
  fsel_t frame_sel;
  logic [COORD_W-1:0] r;
  logic [COORD_W-1:0] c;
  assign wrap = anim_cnt == CW'(ANIM_DIV - 1);
  assign r = q.y >> SCALE_LOG2;
  assign c = q.x >> SCALE_LOG2;
  always_comb begin
    phase = step == 2'd2 ? PH_CLOSED : step[0] ? PH_HALF : PH_OPEN;
    frame_sel = state != ST_ALIVE ? fsel_t'(9 + (state == ST_DEAD ? 7 : int'(dframe)))
              : phase == PH_CLOSED || dir_q == DIR_NONE ? '0
              : fsel_t'({dir_q[1] | dir_q[0], dir_q[2] | dir_q[0], step[0]}) + 1'b1;
  end
  pac_sprite_rom #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .COORD_W(COORD_W)) u_rom (
    .frame_sel(frame_sel), .r(r), .c(c), .on(on));
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_NONE;
      step <= '0;
      anim_cnt <= '0;
      state <= ST_ALIVE;
      dframe <= '0;
      q.pix_valid <= 1'b0;
      q.pixel <= 1'b0;
    end else begin
      q.pix_valid <= q.pix_req;
      q.pixel <= q.pix_req && on;
      if (frame_tick && $onehot(direction)) dir_q <= direction;
`ifdef PAC_DEATH_ANIM_EN
      if (state == ST_ALIVE && die) begin
        state <= ST_DYING;
        dframe <= '0;
        anim_cnt <= '0;
      end else if (state != ST_ALIVE && revive) begin
        state <= ST_ALIVE;
        step <= '0;
        anim_cnt <= '0;
      end else if (state == ST_DYING && frame_tick) begin
        anim_cnt <= wrap ? '0 : anim_cnt + 1'b1;
        if (wrap) dframe <= dframe + 1'b1;
        if (wrap && dframe == 3'd7) state <= ST_DEAD;
      end else
`endif
      if (state == ST_ALIVE && frame_tick && moving) begin
        anim_cnt <= wrap ? '0 : anim_cnt + 1'b1;
        step <= step + 2'(wrap);
      end
    end
  end
`ifdef PAC_DEATH_ANIM_EN
  assign dead_done = state == ST_DEAD;
`else
  logic unused_ok;
  assign unused_ok = die ^ revive;
  assign dead_done = 1'b0;
`endif
endmodule

// File: doc/pac_sprite_anim.md
Name: pac_sprite_anim

Overview:
- Parametrised, animated Pac-Man sprite pixel generator; successor to the fixed 12x12, scale-2, static-direction sprite lookup.
- Adds a chomp animation (open/half/closed mouth), direction latching at frame boundaries, a registered 1-cycle pixel pipeline and an optional death sequence.
- Sits between the VGA scan/position logic and the pixel mux; queried per pixel inside the Pac-Man bounding box.

Parameters:
- SPRITE_W, 12, bitmap width in source pixels
- SPRITE_H, 12, bitmap height in source pixels
- SCALE_LOG2, 1, screen pixels per source pixel = 2**SCALE_LOG2 in each axis
- COORD_W, 5, width of x/y inputs; must satisfy 2**COORD_W >= max(SPRITE_W,SPRITE_H) << SCALE_LOG2
- ANIM_DIV, 4, frame_tick pulses per animation step (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- direction  in  4  one-hot L=1000 U=0100 R=0010 D=0001
- moving  in  1  1 = Pac-Man moving; 0 freezes animation
- pix_req  in  1  pixel query valid
- x  in  COORD_W  column offset inside sprite box
- y  in  COORD_W  row offset inside sprite box
- die  in  1  one-cycle death trigger
- revive  in  1  one-cycle revive trigger
- pix_valid  out  1  pixel result valid
- pixel  out  1  1 = Pac-Man colour at queried point
- dead_done  out  1  death sequence finished

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset values: pix_valid=0, pixel=0, dead_done=0, dir_q=NONE, step=0, anim_cnt=0, state=ALIVE.
- Direction latch: on a frame_tick cycle with direction one-hot, dir_q <= direction. A zero or multi-hot direction keeps dir_q. The new value is used from the next cycle, so a frame is never torn mid-scan.
- Animation counter: on frame_tick with moving=1 and state=ALIVE, anim_cnt increments. At ANIM_DIV-1 it wraps to 0 and step <= step+1 mod 4. When moving=0, anim_cnt and step hold.
- Step to phase: 0=OPEN, 1=HALF, 2=CLOSED, 3=HALF.
- Frame select: CLOSED or dir_q=NONE selects the round body bitmap. Otherwise the bitmap is chosen by {dir_q, phase}: 4 directions x {OPEN, HALF}.
- Lookup: c = x>>SCALE_LOG2, r = y>>SCALE_LOG2. If c>=SPRITE_W or r>=SPRITE_H the pixel is 0.
- Bit index: bitmap bit [(SPRITE_H-1-r)*SPRITE_W + (SPRITE_W-1-c)], so the leftmost character of a row literal is column 0.
- Pipeline: pix_valid(t+1)=pix_req(t). pixel(t+1) is the lookup of x/y(t) using the state as it stood at t. When pix_valid=0, pixel=0.
- Simultaneous events: rst overrides everything.
- rst asserted mid-sequence returns to ALIVE/OPEN at the next edge.

Optional Feature:
- Macro: PAC_DEATH_ANIM_EN.
- Defined, state machine: ALIVE -> DYING on die.
- In DYING, a death frame index 0..7 advances once per ANIM_DIV frame_ticks, regardless of moving. Frames are a progressively widening upward-opening wedge; frame 7 is blank.
- After frame 7 completes: DYING -> DEAD. In DEAD, pixel=0 and dead_done=1.
- DEAD -> ALIVE on revive, with step=0, anim_cnt=0 and dir_q held.
- die during DYING or DEAD is ignored. revive during DYING aborts to ALIVE.
- Not defined: die and revive are ignored, dead_done is tied 0 and the state is always ALIVE. Ports remain present.

Decomposition:
- Package pac_sprite_pkg: direction one-hot constants, phase enum {OPEN, HALF, CLOSED}, state enum {ALIVE, DYING, DEAD}.
- Package also holds the 9 body bitmaps: round, plus L/U/R/D x OPEN/HALF. It holds the 8 death bitmaps under the macro.
- Sub-module pac_sprite_rom: purely combinational (frame_sel, r, c) -> bit, including the out-of-range clamp.
- The top level holds the counters, state machine and output register.

Test Plan:
- Reset then pix_req=1, x=0..23, y=11 -> pix_valid one cycle later. Pixel row matches the round bitmap row 5, with each bit repeated twice.
- direction=1000 and moving=1, then 1 frame_tick -> the left-facing OPEN bitmap from the next cycle.
- Then 4 more ticks with ANIM_DIV=4 -> HALF; 8 more ticks -> CLOSED; 16 ticks after the first step -> back to OPEN.
- moving=0 across 20 ticks -> step and output unchanged.
- direction changes 1000->0001 without a tick -> output still L.
- Then direction=0011 with a tick -> dir_q stays L.
- x=24, y=5 with pix_req=1 -> pixel=0, pix_valid=1. Query at SCALE_LOG2=0 with x=11, y=11 -> bit (11,11) of the selected bitmap.
- With PAC_DEATH_ANIM_EN, ANIM_DIV=2: die, then 16 ticks -> dead_done=1 and pixel=0 everywhere. Then revive -> ALIVE and OPEN. Then rst during DYING -> ALIVE next cycle with dead_done=0.
